// File: rtl/instr_bus_router.sv
// -----------------------------------------------------------------------------
// instr_bus_router
//
// Routes one Ibex-style instruction fetch master onto N_SLAVES instruction bus
// slaves (boot ROM, code RAM, flash, ...). Each request address is decoded
// against per-slave base/mask pairs. The req/gnt handshake is forwarded
// combinationally to the selected slave. Granted-but-unanswered fetches are
// remembered in a small tag FIFO so responses reach the core in issue order.
//
// Optional feature macro: INSTR_BUS_ROUTER_ERR_RESP_EN
//   defined   : unmapped addresses go to an internal error target that grants
//               at once and answers one cycle later with m_err=1, m_rdata=0.
//   undefined : unmapped addresses fall through to slave 0.
//
// Parameters
//   N_SLAVES        number of downstream slaves (1..8)
//   MAX_OUTSTANDING tag FIFO depth (1..4)
//   SLAVE_BASE      per-slave base address, entry [i] belongs to slave i
//   SLAVE_MASK      per-slave match mask; slave i hits when
//                   (m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]
//
// Ports
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   m_req     in   master request
//   m_addr    in   master word address (held by master until granted)
//   m_gnt     out  grant to master
//   m_rvalid  out  response valid to master
//   m_err     out  response error
//   m_rdata   out  response data
//   s_req     out  per-slave request, at most one bit set
//   s_addr    out  shared slave address, equal to m_addr
//   s_gnt     in   per-slave grant
//   s_rvalid  in   per-slave response valid
//   s_err     in   per-slave response error
//   s_rdata   in   per-slave read data, slave i at [32*i +: 32]
// -----------------------------------------------------------------------------
module instr_bus_router #(
  parameter int unsigned                N_SLAVES        = 3,
  parameter int unsigned                MAX_OUTSTANDING = 2,
  parameter logic [N_SLAVES-1:0][31:0] SLAVE_BASE      = {32'h8000_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [N_SLAVES-1:0][31:0] SLAVE_MASK      = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_req,
  input  logic [31:0]           m_addr,
  output logic                  m_gnt,
  output logic                  m_rvalid,
  output logic                  m_err,
  output logic [31:0]           m_rdata,
  output logic [N_SLAVES-1:0]   s_req,
  output logic [31:0]           s_addr,
  input  logic [N_SLAVES-1:0]   s_gnt,
  input  logic [N_SLAVES-1:0]   s_rvalid,
  input  logic [N_SLAVES-1:0]   s_err,
  input  logic [N_SLAVES*32-1:0] s_rdata
);

  // Index width leaves room for the error target at index N_SLAVES.
  localparam int unsigned IDX_W = $clog2(N_SLAVES + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
`ifdef INSTR_BUS_ROUTER_ERR_RESP_EN
  localparam logic [IDX_W-1:0] ERR_IDX  = IDX_W'(N_SLAVES);
`endif

  // Pointers step modulo the depth, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] head;
  logic             sel_gnt;
  logic             head_rvalid;
  logic             head_err;
  logic [31:0]      head_rdata;
  logic             switch_stall;
  logic             can_issue;
  logic             issue;
  logic             push;
  logic             pop;

  logic [IDX_W-1:0] tag_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] last_q, last_d;
`ifdef INSTR_BUS_ROUTER_ERR_RESP_EN
  logic             err_resp_q, err_resp_d;
`endif

  assign s_addr = m_addr;

  // ---------------------------------------------------------------------------
  // Address decode: iterate from the top so the lowest matching index wins.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any conditional
  // assignment; without it a missed branch would infer a latch.
  always_comb begin
`ifdef INSTR_BUS_ROUTER_ERR_RESP_EN
    sel = ERR_IDX;
`else
    sel = '0;
`endif
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
        sel = IDX_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response path: only the FIFO head may answer, and only with a fetch in
  // flight; anything else on s_rvalid is dropped.
  // ---------------------------------------------------------------------------
  assign head = tag_q[rd_ptr_q];

  always_comb begin
    head_rvalid = 1'b0;
    head_err    = 1'b0;
    head_rdata  = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (head == IDX_W'(i)) begin
        head_rvalid = s_rvalid[i];
        head_err    = s_err[i];
        head_rdata  = s_rdata[i*32 +: 32];
      end
    end
`ifdef INSTR_BUS_ROUTER_ERR_RESP_EN
    if (head == ERR_IDX) begin
      head_rvalid = err_resp_q;
      head_err    = 1'b1;
      head_rdata  = '0;
    end
`endif
  end

  assign m_rvalid = rst_n & (count_q != '0) & head_rvalid;
  assign m_err    = head_err;
  assign m_rdata  = head_rdata;
  assign pop      = m_rvalid;

  // ---------------------------------------------------------------------------
  // Request path. A target change waits until every in-flight fetch has
  // drained, so two slaves can never race to answer. The pop term lets a full
  // FIFO accept a new fetch in the same cycle the oldest one completes.
  // ---------------------------------------------------------------------------
  assign switch_stall = (count_q != '0) && (sel != last_q);
  assign can_issue    = ((count_q < MAX_CNT) || pop) && !switch_stall;
  assign issue        = rst_n & m_req & can_issue;

  always_comb begin
    s_req   = '0;
    sel_gnt = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel == IDX_W'(i)) begin
        s_req[i] = issue;
        sel_gnt  = s_gnt[i];
      end
    end
`ifdef INSTR_BUS_ROUTER_ERR_RESP_EN
    if (sel == ERR_IDX) begin
      sel_gnt = 1'b1;
    end
`endif
  end

  assign m_gnt = issue & sel_gnt;
  assign push  = m_req & m_gnt;

  // ---------------------------------------------------------------------------
  // Tag FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    last_d   = push ? sel : last_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

`ifdef INSTR_BUS_ROUTER_ERR_RESP_EN
  // The error target answers exactly one cycle after it is granted.
  assign err_resp_d = push && (sel == ERR_IDX);
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_q     <= '0;
`ifdef INSTR_BUS_ROUTER_ERR_RESP_EN
      err_resp_q <= 1'b0;
`endif
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_q     <= last_d;
`ifdef INSTR_BUS_ROUTER_ERR_RESP_EN
      err_resp_q <= err_resp_d;
`endif
    end
  end

  // NOTE: the tag storage is deliberately not reset; an entry is only read
  // while count_q says it holds a live tag, so its reset value never matters.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_instr_bus_router.sv
// -----------------------------------------------------------------------------
// tb_instr_bus_router
//
// Directed bench for instr_bus_router with its default parameters (3 slaves,
// depth 2). Each slave is a small model that grants at once and answers a
// granted fetch after a fixed latency with data = address ^ salt. Every grant
// seen by the master driver pushes the hand-computed response (data, err and
// the cycle it must appear in) into a scoreboard; an independent monitor pops
// and compares on every m_rvalid.
// -----------------------------------------------------------------------------
module tb_instr_bus_router;

  localparam int NS = 3;
  localparam int LAT [NS] = '{2, 2, 3};
  localparam logic [31:0] SALT [NS] = '{32'hDEADBEFF, 32'hCAFE0000, 32'h0BAD0000};

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            m_req;
  logic [31:0]     m_addr;
  logic            m_gnt;
  logic            m_rvalid;
  logic            m_err;
  logic [31:0]     m_rdata;
  logic [NS-1:0]   s_req;
  logic [31:0]     s_addr;
  logic [NS-1:0]   s_gnt;
  logic [NS-1:0]   s_rvalid;
  logic [NS-1:0]   s_err;
  logic [NS*32-1:0] model_rdata = '0;
  logic [NS-1:0]   model_rv = '0;
  logic [NS-1:0]   stray;

  rsp_t pq [NS][$];
  exp_t sb [$];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  assign s_gnt    = '1;
  assign s_err    = '0;
  assign s_rvalid = model_rv | stray;

  instr_bus_router dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_err    (m_err),
    .m_rdata  (m_rdata),
    .s_req    (s_req),
    .s_addr   (s_addr),
    .s_gnt    (s_gnt),
    .s_rvalid (s_rvalid),
    .s_err    (s_err),
    .s_rdata  (model_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave models: retire the response shown this cycle, queue newly granted fetches.
  always @(negedge clk) begin
    rsp_t r;
    for (int i = 0; i < NS; i++) begin
      while (pq[i].size() > 0 && pq[i][0].due <= cyc) void'(pq[i].pop_front());
      if (s_req[i] && s_gnt[i]) begin
        r.due  = cyc + LAT[i];
        r.data = s_addr ^ SALT[i];
        pq[i].push_back(r);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NS; i++) begin
      model_rv[i]              = 1'b0;
      model_rdata[i*32 +: 32]  = 32'h0;
      if (pq[i].size() > 0 && pq[i][0].due == cyc) begin
        model_rv[i]             = 1'b1;
        model_rdata[i*32 +: 32] = pq[i][0].data;
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (m_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rvalid: m_rvalid=1 with nothing expected (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("rsp_data", m_rdata, e.data);
        check("rsp_err", 32'(m_err), 32'(e.err));
        check("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Presents one fetch and holds it until granted. Returns the grant cycle and
  // the first cycle s_req[idx] was seen high (idx >= NS skips that probe).
  // Leaves m_req asserted; the caller either issues again or goes idle.
  task automatic issue(input logic [31:0] addr, input logic [31:0] exp_data,
                       input logic exp_err, input int lat, input int idx,
                       output int gcyc, output int first_req);
    exp_t e;
    m_req     = 1'b1;
    m_addr    = addr;
    gcyc      = -1;
    first_req = -1;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (idx < NS && first_req < 0 && s_req[idx] === 1'b1) first_req = cyc;
      if (m_gnt === 1'b1) begin
        gcyc   = cyc;
        e.data = exp_data;
        e.err  = exp_err;
        e.cyc  = cyc + lat;
        sb.push_back(e);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (gcyc < 0) begin
      total++;
      bad++;
      $display("FAIL grant_timeout: no m_gnt for addr %h within 20 cycles", addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    m_req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, g0, g1, g2, f0, f1;
    rst_n  = 1'b0;
    m_req  = 1'b0;
    m_addr = 32'h0;
    stray  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset forces handshake outputs low even with a request pending
    m_req  = 1'b1;
    m_addr = 32'h0000_0010;
    @(negedge clk);
    check("rst_s_req", 32'(s_req), 32'h0);
    check("rst_m_gnt", 32'(m_gnt), 32'h0);
    check("rst_m_rvalid", 32'(m_rvalid), 32'h0);
    @(posedge clk);
    #1;
    m_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_count", 32'(dut.count_q), 32'h0);
    @(posedge clk);
    #1;

    // 1: single fetch to slave 0, response two cycles after the grant
    c = cyc;
    issue(32'h0000_0010, 32'hDEADBEEF, 1'b0, 2, 0, g0, f0);
    idle(3);
    check("t1_gnt_cycle", g0, c);
    @(negedge clk);
    check("t1_count_drained", 32'(dut.count_q), 32'h0);
    @(posedge clk);
    #1;

    // 2: back-to-back to slave 1; the third grant rides on the first pop
    c = cyc;
    issue(32'h0001_0000, 32'hCAFF0000, 1'b0, 2, 1, g0, f0);
    issue(32'h0001_0004, 32'hCAFF0004, 1'b0, 2, 1, g1, f0);
    issue(32'h0001_0008, 32'hCAFF0008, 1'b0, 2, 1, g2, f0);
    idle(4);
    check("t2_gnt0_cycle", g0, c);
    check("t2_gnt1_cycle", g1, c + 1);
    check("t2_gnt2_cycle", g2, c + 2);

    // 3: slave 0 then slave 2; slave 2 must wait for the FIFO to empty
    c = cyc;
    issue(32'h0000_0020, 32'hDEADBEDF, 1'b0, 2, 0, g0, f0);
    issue(32'h8000_0100, 32'h8BAD0100, 1'b0, 3, 2, g1, f1);
    idle(5);
    check("t3_gnt0_cycle", g0, c);
    check("t3_sreq2_first", f1, c + 3);
    check("t3_gnt1_cycle", g1, c + 3);

    // 4: unmapped address
    c = cyc;
`ifdef INSTR_BUS_ROUTER_ERR_RESP_EN
    issue(32'h4000_0000, 32'h0000_0000, 1'b1, 1, NS, g0, f0);
`else
    issue(32'h4000_0000, 32'h9EADBEFF, 1'b0, 2, 0, g0, f0);
    check("t4_sreq0_first", f0, c);
`endif
    idle(3);
    check("t4_gnt_cycle", g0, c);

    // 5: stray s_rvalid[2], first with nothing in flight, then with slave 0 at head
    stray = 3'b100;
    @(negedge clk);
    check("t5_idle_rvalid", 32'(m_rvalid), 32'h0);
    check("t5_idle_count", 32'(dut.count_q), 32'h0);
    @(posedge clk);
    #1;
    stray = '0;
    c = cyc;
    issue(32'h0000_0000, 32'hDEADBEFF, 1'b0, 2, 0, g0, f0);
    m_req = 1'b0;
    stray = 3'b100;
    @(negedge clk);
    check("t5_head_rvalid", 32'(m_rvalid), 32'h0);
    check("t5_head_count", 32'(dut.count_q), 32'h1);
    @(posedge clk);
    #1;
    stray = '0;
    idle(3);
    check("t5_gnt_cycle", g0, c);

    // 6: reset with two fetches to slave 2 outstanding
    c = cyc;
    issue(32'h8000_0000, 32'h8BAD0000, 1'b0, 3, 2, g0, f0);
    issue(32'h8000_0004, 32'h8BAD0004, 1'b0, 3, 2, g1, f0);
    m_req = 1'b0;
    check("t6_gnt0_cycle", g0, c);
    check("t6_gnt1_cycle", g1, c + 1);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t6_rst_rvalid", 32'(m_rvalid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_count_after_rst", 32'(dut.count_q), 32'h0);
    check("t6_late_rsp0", 32'(m_rvalid), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_late_rsp1", 32'(m_rvalid), 32'h0);
    @(posedge clk);
    #1;
    c = cyc;
    issue(32'h0000_0000, 32'hDEADBEFF, 1'b0, 2, 0, g0, f0);
    idle(4);
    check("t6_new_gnt_cycle", g0, c);
    @(negedge clk);
    check("final_count", 32'(dut.count_q), 32'h0);
    check("final_sb_empty", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
